// File: rtl/epb_bus_ctrl_pkg.sv
// Shared types and constants for the EPB slave sequencer.
// The EPB_CTRL_TIMEOUT_EN build option is consumed by epb_bus_ctrl.
package epb_ctrl_pkg;

  localparam int EPB_DATA_W = 32;
  localparam int EPB_BE_W   = 4;

  localparam logic [EPB_DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } epb_state_e;

endpackage

// File: rtl/epb_bus_ctrl_sync.sv
// Parameterised-width two-flop synchroniser; both stages reset to 1 so the
// idle-high EPB strobes never look asserted coming out of reset.
module epb_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/epb_bus_ctrl.sv
// EPB slave sequencer: one request/acknowledge on the register bus per EPB access.
// Define EPB_CTRL_TIMEOUT_EN to force completion (with err_o) after TIMEOUT_CYC cycles in REQ.
module epb_bus_ctrl
  import epb_ctrl_pkg::*;
#(
  parameter int                      ADDR_W      = 24,
  parameter int                      TIMEOUT_CYC = 1024,
  parameter logic [EPB_DATA_W-1:0]   ERR_RDATA   = ERR_RDATA_DEF
) (
  input  logic                  epb_clk_i,
  input  logic                  epb_rst_n_i,
  input  logic                  epb_cs_n_i,
  input  logic                  epb_oe_n_i,
  input  logic                  epb_we_n_i,
  input  logic [EPB_BE_W-1:0]   epb_be_n_i,
  input  logic [ADDR_W-1:0]     epb_addr_i,
  input  logic [EPB_DATA_W-1:0] epb_data_in_i,
  output logic [EPB_DATA_W-1:0] epb_data_out_o,
  output logic                  epb_data_oe_n_o,
  output logic                  epb_rdy_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [EPB_BE_W-1:0]   bus_be_o,
  output logic [EPB_DATA_W-1:0] bus_wdata_o,
  input  logic [EPB_DATA_W-1:0] bus_rdata_i,
  input  logic                  bus_ack_i,
  output logic                  err_o
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("epb_bus_ctrl: TIMEOUT_CYC must lie in 2..65535");
  end

  epb_state_e state_q, state_d;

  logic cs_s, oe_s, we_s;
  logic cs_prev_q;
  logic cs_fall, tmo_hit, ack_ev, tmo_ev, capture;

  logic                  req_q, req_d, rdy_q, rdy_d, oe_n_q, oe_n_d, err_q, err_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [EPB_BE_W-1:0]   be_q, be_d;
  logic [EPB_DATA_W-1:0] wdata_q, wdata_d, dout_q, dout_d;

  epb_sync #(.W(3)) u_sync (
    .clk_i   (epb_clk_i),
    .rst_n_i (epb_rst_n_i),
    .async_i ({epb_cs_n_i, epb_oe_n_i, epb_we_n_i}),
    .sync_o  ({cs_s, oe_s, we_s})
  );

  assign cs_fall = cs_prev_q & ~cs_s;

`ifdef EPB_CTRL_TIMEOUT_EN
  logic [15:0] cnt_q;

  // Counter restarts from 0 on every entry into REQ.
  always_ff @(posedge epb_clk_i or negedge epb_rst_n_i) begin
    if (!epb_rst_n_i) cnt_q <= '0;
    else if (state_q == REQ) cnt_q <= cnt_q + 16'd1;
    else cnt_q <= '0;
  end

  assign tmo_hit = (state_q == REQ) && (cnt_q == 16'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge epb_clk_i or negedge epb_rst_n_i) begin
    if (!epb_rst_n_i) begin
      state_q   <= IDLE;
      cs_prev_q <= 1'b1;
      req_q     <= 1'b0;
      rdy_q     <= 1'b0;
      oe_n_q    <= 1'b1;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cs_prev_q <= cs_s;
      req_q     <= req_d;
      rdy_q     <= rdy_d;
      oe_n_q    <= oe_n_d;
      err_q     <= err_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
    end
  end

  // Host abort (cs_s high) outranks a same-cycle ack or timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = REQ;
      REQ:     if (cs_s) state_d = IDLE;
               else if (bus_ack_i || tmo_hit) state_d = DONE;
      DONE:    if (cs_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture = (state_q == IDLE) && cs_fall;
    ack_ev  = (state_q == REQ) && !cs_s && bus_ack_i;
    tmo_ev  = (state_q == REQ) && !cs_s && !bus_ack_i && tmo_hit;

    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    if (capture) begin
      we_d    = ~we_s;
      addr_d  = epb_addr_i;
      be_d    = ~epb_be_n_i;
      wdata_d = epb_data_in_i;
    end
    if (ack_ev && !we_q)      dout_d = bus_rdata_i;
    else if (tmo_ev && !we_q) dout_d = ERR_RDATA;

    req_d  = (state_d == REQ);
    rdy_d  = (state_d == DONE);
    // Drive the pads only while the host read strobe is low to avoid contention.
    oe_n_d = (state_d == DONE && !we_q) ? oe_s : 1'b1;
    err_d  = tmo_ev;
  end

  assign epb_data_out_o  = dout_q;
  assign epb_data_oe_n_o = oe_n_q;
  assign epb_rdy_o       = rdy_q;
  assign bus_req_o       = req_q;
  assign bus_we_o        = we_q;
  assign bus_addr_o      = addr_q;
  assign bus_be_o        = be_q;
  assign bus_wdata_o     = wdata_q;
`ifdef EPB_CTRL_TIMEOUT_EN
  assign err_o           = err_q;
`else
  assign err_o           = 1'b0;
  logic unused_err;
  assign unused_err      = err_q;
`endif

endmodule

// File: doc/epb_bus_ctrl.md
Name: epb_bus_ctrl

Overview:
- Slave-side sequencer for the ROACH2 EPB (PowerPC external peripheral bus).
- Synchronises the asynchronous EPB strobes and captures address, byte enables and write data.
- Runs one request/acknowledge transaction on the internal register bus per EPB access.
- Drives the tristate buffer's output-enable and output data, plus the EPB ready line.
- Sits between the EPB pad-level tristate infrastructure and the internal register fabric.

Parameters:
- ADDR_W, 24, EPB address width.
- TIMEOUT_CYC, 1024, maximum number of cycles in REQ before the access is forced to complete (range 2..65535).
- ERR_RDATA, 32'hDEAD_DEAD, read data returned on a timed-out read.

Ports:
- epb_clk_i  in  1  Fabric/EPB clock (one clock domain).
- epb_rst_n_i  in  1  Reset, asynchronous, active-low.
- epb_cs_n_i  in  1  EPB chip select, asynchronous.
- epb_oe_n_i  in  1  EPB output-enable (read strobe), asynchronous.
- epb_we_n_i  in  1  EPB write enable, asynchronous.
- epb_be_n_i  in  4  EPB byte enables, active-low.
- epb_addr_i  in  ADDR_W  EPB address.
- epb_data_in_i  in  32  Data received from the tristate buffer.
- epb_data_out_o  out  32  Data to the tristate buffer.
- epb_data_oe_n_o  out  1  Tristate output-enable, active-low.
- epb_rdy_o  out  1  EPB ready to host.
- bus_req_o  out  1  Internal register-bus request (level).
- bus_we_o  out  1  1 = write, 0 = read.
- bus_addr_o  out  ADDR_W  Internal register-bus address.
- bus_be_o  out  4  Byte enables, active-high.
- bus_wdata_o  out  32  Internal register-bus write data.
- bus_rdata_i  in  32  Internal register-bus read data.
- bus_ack_i  in  1  Internal register-bus acknowledge (single-cycle).
- err_o  out  1  One-cycle pulse on timeout.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - State IDLE, epb_data_oe_n_o=1, epb_rdy_o=0, bus_req_o=0, err_o=0.
  - All data, address and byte-enable registers = 0.
  - Synchroniser flops reset to 1.
- Synchronisation: cs_n, oe_n and we_n each pass through 2 flops (cs_s, oe_s, we_s).
  - Address, byte enables and data are sampled directly; EPB timing holds them stable while cs_n is low.
- IDLE: on cs_s falling edge (cs_s=0, previous cs_s=1):
  - Latch bus_addr_o=epb_addr_i, bus_be_o=~epb_be_n_i, bus_we_o=~we_s, bus_wdata_o=epb_data_in_i.
  - Go to REQ; bus_req_o=1 on the next cycle.
  - Worst-case latency from cs_n pin fall to req is 4 cycles.
- REQ: hold bus_req_o=1; count cycles from 0.
  - bus_ack_i=1: bus_req_o=0 on the next cycle. On reads, epb_data_out_o=bus_rdata_i. Go to DONE.
  - Acknowledge arriving on the first REQ cycle is legal.
  - cs_s=1 (host abort) takes priority over a same-cycle ack: req dropped, ack ignored, go to IDLE, no rdy.
- DONE:
  - epb_rdy_o=1.
  - Reads: epb_data_oe_n_o = oe_s, i.e. drive only while the host read strobe is low, to avoid bus contention.
  - Writes: epb_data_oe_n_o stays 1 throughout.
  - Remain until cs_s=1. The next cycle gives rdy=0, oe_n=1, state IDLE.
  - A new access needs a fresh cs_s falling edge, so back-to-back accesses need cs_n high for at least 2 cycles.
- Ack outside REQ: ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states: IDLE, REQ, DONE.

Optional Feature:
- EPB_CTRL_TIMEOUT_EN defined:
  - If the REQ counter reaches TIMEOUT_CYC-1 with no ack, the next cycle drops req and pulses err_o for 1 cycle.
  - Reads return epb_data_out_o=ERR_RDATA; the FSM enters DONE.
  - An ack arriving on the terminal-count cycle wins; no error is raised.
- Not defined: no counter, err_o tied to 0, REQ waits indefinitely.

Decomposition:
- Package epb_ctrl_pkg holds:
  - State enum (IDLE, REQ, DONE).
  - EPB_DATA_W=32 and EPB_BE_W=4.
  - Default ERR_RDATA constant.
- Sub-module epb_sync: parameterised-width 2-flop synchroniser with reset to 1. Instantiated once for {cs_n, oe_n, we_n}.

Test Plan:
1. Write addr 0x000010, data 0x12345678, be_n=4'b0000; ack 3 cycles after req:
   - One req pulse with bus_we_o=1, bus_be_o=4'hF, matching wdata.
   - rdy rises the cycle after ack; oe_n stays 1.
   - rdy falls 1 cycle after cs_s rises.
2. Read addr 0x000020; rdata=0xCAFEF00D, ack in the same cycle as req rises:
   - epb_data_out_o=0xCAFEF00D.
   - oe_n=0 only while oe_s=0; rdy=1 until cs_n returns high.
3. Timeout with EPB_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16; read with no ack:
   - req held 16 cycles, then err_o pulses once.
   - data_out=0xDEADDEAD, rdy=1.
4. Host abort: cs_n rises 2 cycles into REQ, ack asserted in the same cycle as cs_s rising:
   - req drops, no rdy, state IDLE, ack ignored.
5. Reset asserted in DONE during a read:
   - oe_n=1, rdy=0, req=0 immediately, without waiting for a clock edge.
   - After release, the next cs_n fall starts a clean access.
6. Two back-to-back writes separated by cs_n high for 2 cycles: exactly 2 req/ack handshakes with the correct per-access addresses.
